adc_sample_capture: RTL and testbench

Capture and buffering stage directly downstream of the SAR ADC slice in `core`. The block samples the ADC's 9-bit conversion result once per conversion period and optionally block-averages 2^LOG2_AVG samples. It queues the results in a small FIFO and presents them on a valid/ready port to the digital consumer: the SPI, TileLink serializer, or a GPIO debug path. It runs on the same `clock` that drives the ADC.

---
 rtl/adc_sample_capture.sv | 135 +++++++++++++
 tb/tb_adc_sample_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_capture
// Purpose  : Phase-timed ADC capture, optional block averaging, valid/ready FIFO.
// Revision : 1.0
// ============================================================================
module adc_sample_capture #(
  parameter int DATA_W       = 9,
  parameter int CONV_CYCLES  = 16,
  parameter int SAMPLE_PHASE = 15,
  parameter int LOG2_AVG     = 2,
  parameter int DEPTH        = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        adc_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_bits,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clear,
  output logic                     sample_strobe
);

  localparam int PH_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int AW    = $clog2(DEPTH);

  logic [PH_W-1:0]   r_phase;
  logic [DATA_W-1:0] r_sample;
  logic              r_strobe;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_hold;

  logic              w_capture;
  logic              w_last;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_result;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_write;
  logic              w_drop;

  assign w_capture = enable && (r_phase == PH_W'(SAMPLE_PHASE));
  assign w_last    = (r_acc_cnt == CNT_W'((2 ** LOG2_AVG) - 1));
  // Sum cannot overflow: at most 2^LOG2_AVG full-scale samples fit in ACC_W bits.
  assign w_sum     = r_acc + ACC_W'(r_sample);
  assign w_result  = DATA_W'(w_sum >> LOG2_AVG);

  assign w_push  = r_strobe && w_last;
  assign w_pop   = out_valid && out_ready;
  assign w_full  = (r_count == (AW + 1)'(DEPTH));
  assign w_write = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase  <= '0;
      r_sample <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_capture;
      if (w_capture) r_sample <= adc_data;
      if (!enable)
        r_phase <= '0;
      else if (r_phase == PH_W'(CONV_CYCLES - 1))
        r_phase <= '0;
      else
        r_phase <= r_phase + 1'b1;
    end
  end

  // A capture registered just before enable drops still pushes its result,
  // but a partial block is discarded.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end else if (r_strobe) begin
      if (w_last) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end else begin
        r_acc     <= w_sum;
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_write && !reset) r_mem[r_wr_ptr] <= w_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hold     <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      if (w_write && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_write)
        r_count <= r_count - 1'b1;
      if (w_drop)
        r_overflow <= 1'b1;
      else if (overflow_clear)
        r_overflow <= 1'b0;
    end
  end

  assign out_valid     = (r_count != '0);
  assign out_bits      = out_valid ? r_mem[r_rd_ptr] : r_hold;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign sample_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_capture
// Purpose  : Directed bench for adc_sample_capture (LOG2_AVG=0 and 2 instances).
// Revision : 1.0
// ============================================================================
module tb_adc_sample_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [8:0] adc_data = '0;
  logic       out_ready = 1'b0;
  logic       overflow_clear = 1'b0;

  logic       valid0, ovf0, strobe0;
  logic [8:0] bits0;
  logic [3:0] count0;
  logic       valid2, ovf2, strobe2;
  logic [8:0] bits2;
  logic [3:0] count2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  adc_sample_capture #(.DATA_W(9), .CONV_CYCLES(16), .SAMPLE_PHASE(15),
                       .LOG2_AVG(0), .DEPTH(8)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .adc_data(adc_data),
    .out_valid(valid0), .out_ready(out_ready), .out_bits(bits0), .count(count0),
    .overflow(ovf0), .overflow_clear(overflow_clear), .sample_strobe(strobe0));

  adc_sample_capture #(.DATA_W(9), .CONV_CYCLES(16), .SAMPLE_PHASE(15),
                       .LOG2_AVG(2), .DEPTH(8)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .adc_data(adc_data),
    .out_valid(valid2), .out_ready(out_ready), .out_bits(bits2), .count(count2),
    .overflow(ovf2), .overflow_clear(overflow_clear), .sample_strobe(strobe2));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Drive v and advance until the capture strobe is seen (bounded).
  task automatic run_conv(input logic [8:0] v);
    int n;
    adc_data = v;
    n = 0;
    do begin
      tick();
      n++;
    end while (!strobe0 && n < 40);
    tests++;
    if (strobe0 !== 1'b1) begin
      fails++;
      $display("FAIL conv_timeout: strobe=%b after %0d cycles, required 1", strobe0, n);
    end
  endtask

  task automatic test_reset();
    int strobes;
    reset = 1'b1; enable = 1'b0;
    repeat (3) tick();
    tests++;
    if ({valid0, count0, ovf0, strobe0, bits0} !== {1'b0, 4'd0, 1'b0, 1'b0, 9'd0}) begin
      fails++;
      $display("FAIL reset_idle0: valid=%b count=%0d ovf=%b strobe=%b bits=%h, required 0", valid0, count0, ovf0, strobe0, bits0);
    end
    tests++;
    if ({valid2, count2, ovf2, strobe2} !== 7'd0) begin
      fails++;
      $display("FAIL reset_idle2: valid=%b count=%0d ovf=%b strobe=%b, required 0", valid2, count2, ovf2, strobe2);
    end
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (strobe0 || strobe2) strobes++;
    end
    tests++;
    if (strobes !== 0) begin
      fails++;
      $display("FAIL disabled_strobe: strobes=%0d, required 0", strobes);
    end
  endtask

  task automatic test_capture();
    int strobes;
    do_reset();
    adc_data = 9'h1A5; enable = 1'b1;
    strobes = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (strobe0) strobes++;
    end
    tests++;
    if (strobes !== 0) begin
      fails++;
      $display("FAIL early_strobe: strobes=%0d before cycle 16, required 0", strobes);
    end
    tick();
    tests++;
    if (strobe0 !== 1'b1 || valid0 !== 1'b0) begin
      fails++;
      $display("FAIL strobe_c16: strobe=%b valid=%b, required strobe=1 valid=0", strobe0, valid0);
    end
    tick();
    tests++;
    if (strobe0 !== 1'b0 || valid0 !== 1'b1 || bits0 !== 9'h1A5 || count0 !== 4'd1) begin
      fails++;
      $display("FAIL first_push: strobe=%b valid=%b bits=%h count=%0d, required 0 1 1a5 1", strobe0, valid0, bits0, count0);
    end
    strobes = 0;
    for (int k = 18; k <= 31; k++) begin
      tick();
      if (strobe0) strobes++;
    end
    tick();
    tests++;
    if (strobes !== 0 || strobe0 !== 1'b1) begin
      fails++;
      $display("FAIL strobe_period: extra=%0d strobe_c32=%b, required 0 and 1", strobes, strobe0);
    end
  endtask

  task automatic test_average();
    do_reset();
    enable = 1'b1;
    run_conv(9'd10); run_conv(9'd11); run_conv(9'd12); run_conv(9'd14);
    tests++;
    if (count2 !== 4'd0) begin
      fails++;
      $display("FAIL avg_early: count=%0d, required 0", count2);
    end
    tick();
    tests++;
    if (valid2 !== 1'b1 || bits2 !== 9'd11 || count2 !== 4'd1) begin
      fails++;
      $display("FAIL avg_ramp: valid=%b bits=%0d count=%0d, required 1 11 1", valid2, bits2, count2);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    run_conv(9'd511); run_conv(9'd511); run_conv(9'd511); run_conv(9'd511);
    tick();
    tests++;
    if (bits2 !== 9'd511 || count2 !== 4'd1) begin
      fails++;
      $display("FAIL avg_full_scale: bits=%0d count=%0d, required 511 1", bits2, count2);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    for (int v = 1; v <= 8; v++) run_conv(9'(v));
    tick();
    tests++;
    if (count0 !== 4'd8 || bits0 !== 9'd1 || ovf0 !== 1'b0) begin
      fails++;
      $display("FAIL fill: count=%0d head=%0d ovf=%b, required 8 1 0", count0, bits0, ovf0);
    end
    run_conv(9'd9);
    tick();
    tests++;
    if (count0 !== 4'd8 || ovf0 !== 1'b1 || bits0 !== 9'd1) begin
      fails++;
      $display("FAIL drop9: count=%0d ovf=%b head=%0d, required 8 1 1", count0, ovf0, bits0);
    end
    overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
    tests++;
    if (ovf0 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b, required 0", ovf0);
    end
    run_conv(9'd10);
    overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
    tests++;
    if (ovf0 !== 1'b1 || count0 !== 4'd8) begin
      fails++;
      $display("FAIL set_wins: ovf=%b count=%0d, required 1 8", ovf0, count0);
    end
  endtask

  task automatic test_full_pop();
    logic [8:0] exp;
    overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
    run_conv(9'd11);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tests++;
    if (count0 !== 4'd8 || ovf0 !== 1'b0) begin
      fails++;
      $display("FAIL full_pop: count=%0d ovf=%b, required 8 0", count0, ovf0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 9'(i + 2) : 9'd11;
      tests++;
      if (bits0 !== exp || valid0 !== 1'b1) begin
        fails++;
        $display("FAIL drain_%0d: bits=%0d valid=%b, required %0d 1", i, bits0, valid0, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    enable = 1'b0;
    tests++;
    if (count0 !== 4'd0 || valid0 !== 1'b0) begin
      fails++;
      $display("FAIL drained: count=%0d valid=%b, required 0 0", count0, valid0);
    end
  endtask

  task automatic test_disable_reset();
    do_reset();
    enable = 1'b1;
    run_conv(9'd100); run_conv(9'd100);
    tick();
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    run_conv(9'd20); run_conv(9'd21);
    tests++;
    if (count2 !== 4'd0) begin
      fails++;
      $display("FAIL partial_kept: count=%0d, required 0", count2);
    end
    run_conv(9'd22); run_conv(9'd23);
    tick();
    tests++;
    if (count2 !== 4'd1 || bits2 !== 9'd21) begin
      fails++;
      $display("FAIL reenable_avg: count=%0d bits=%0d, required 1 21", count2, bits2);
    end
    do_reset();
    enable = 1'b1;
    for (int v = 1; v <= 5; v++) run_conv(9'(v * 3));
    tick();
    tests++;
    if (count0 !== 4'd5) begin
      fails++;
      $display("FAIL queued5: count=%0d, required 5", count0);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++;
    if (count0 !== 4'd0 || valid0 !== 1'b0 || count2 !== 4'd0 || valid2 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count0=%0d valid0=%b count2=%0d valid2=%b, required 0", count0, valid0, count2, valid2);
    end
    enable = 1'b1;
    run_conv(9'd40); run_conv(9'd40); run_conv(9'd40);
    tests++;
    if (count2 !== 4'd0) begin
      fails++;
      $display("FAIL reset_acc: count=%0d after 3 samples, required 0", count2);
    end
    run_conv(9'd40);
    tick();
    tests++;
    if (count2 !== 4'd1 || bits2 !== 9'd40) begin
      fails++;
      $display("FAIL post_reset_avg: count=%0d bits=%0d, required 1 40", count2, bits2);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_average();
    test_overflow();
    test_full_pop();
    test_disable_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
